reg_bank_scoreboard: RTL and testbench
======================================

// Module: reg_bank_scoreboard
// PURPOSE
//  32 x N-bit architectural register bank with a per-register busy scoreboard.
//  Sits directly upstream of the 32:1 N-bit register-read muxes: it drives all
//  32 register values as one flattened bus, and each read port's mux selects from it.
//  Also flags read-after-write hazards so the issue stage can stall.
// PARAMETERS
//  N        64   data width of each register
//  ZERO_REG 31   index of the hardwired-zero register (XZR); never written, never busy
// PORTS
//  clk          in   1      system clock; all state updates on rising edge
//  rst_n        in   1      asynchronous, active-low reset
//  wr_en        in   1      writeback strobe
//  wr_addr      in   5      writeback destination register
//  wr_data      in   N      writeback data
//  issue_en     in   1      an instruction with a destination is issuing this cycle
//  issue_rd     in   5      destination register of the issuing instruction
//  flush        in   1      pipeline flush; clears all busy bits
//  rs_a         in   5      source register A of the instruction in decode
//  rs_b         in   5      source register B of the instruction in decode
//  q_all        out  32*N   register i at bits [i*N +: N]; feeds the 32:1 read muxes
//  busy         out  32     scoreboard vector; bit i set = reg i has a pending write
//  hazard_a     out  1      busy[rs_a], combinational
//  hazard_b     out  1      busy[rs_b], combinational
//  stall        out  1      hazard_a | hazard_b
// BEHAVIOUR
//  Reset (rst_n low, async): all 32 registers = 0; busy = 0.
//   Hence q_all = 0, hazard_a = hazard_b = stall = 0.
//  Write: at posedge, if wr_en and wr_addr != ZERO_REG, then reg[wr_addr] <= wr_data.
//   - Visible on q_all from the following cycle; no write-to-read bypass.
//   - Writes to ZERO_REG are dropped.
//   - q_all slice ZERO_REG is the constant 0; it is never a flop.
//  Scoreboard update at posedge, highest priority first:
//   1. flush: busy <= 0; overrides issue and writeback clear. Register data is still written.
//   2. issue_en and issue_rd != ZERO_REG: set busy[issue_rd].
//   3. wr_en and wr_addr != ZERO_REG: clear busy[wr_addr].
//   - Issue and writeback to the same register in the same cycle: busy stays 1
//     (new producer wins). The data write still occurs.
//   - Issue and writeback to different registers: both take effect.
//   - Writeback to a non-busy register: data is written; busy is unchanged (0).
//   - Issue to a register that is already busy: it stays busy (no counting, single outstanding).
//  Hazards: hazard_x = busy[rs_x] from current state.
//   - rs_x == ZERO_REG always gives 0.
//   - A writeback clearing busy in the current cycle does NOT suppress the hazard
//     this cycle; stall drops on the next cycle.
//  Latency: write to q_all 1 cycle; issue to busy 1 cycle; busy to stall 0 cycles.
//  Reset asserted mid-operation clears data and scoreboard immediately.
//   First writes/issues are accepted on the first posedge after rst_n deasserts.
// STRUCTURE
//  Shared package (regfile_pkg):
//   - NREG = 32
//   - REG_AW = 5
//   - XZR = 5'd31
//   - default N = 64
//   - typedef reg_idx_t = logic [4:0]
//  Sub-module: decoder_5to32 (one-hot, with enable). Instanced twice:
//   - write-enable decode
//   - issue-set decode
//  One flop row per register i != ZERO_REG.
//  Scoreboard is a 32-bit vector: next = flush ? 0 : (busy | set_oh) & ~(clr_oh & ~set_oh).
// TESTING
//  1. Reset:
//     - Drive rst_n=0 mid-run with regs nonzero -> q_all=0 and busy=0 with no clock edge.
//     - Release, then write reg5=64'hDEAD_BEEF_0000_0001 -> slice 5 equals it next cycle.
//  2. XZR:
//     - wr_en, wr_addr=31, wr_data=all-ones -> slice 31 stays 0.
//     - issue_rd=31 -> busy[31]=0.
//     - rs_a=31 -> hazard_a=0.
//  3. RAW stall:
//     - issue_rd=7; next cycle rs_b=7 -> stall=1.
//     - wr_en wr_addr=7 data=0x42 -> stall still 1 that cycle; next cycle stall=0 and slice 7=0x42.
//  4. Same-cycle collision:
//     - busy[3]=1; issue_rd=3 and wr_addr=3 together -> busy[3]=1 after the edge, slice 3 updated.
//     - Same collision with wr_addr=4 -> busy[3]=1 and busy[4]=0.
//  5. Flush:
//     - busy=0x0000_00F0; flush together with issue_rd=9 and wr_en to reg 4 ->
//       busy=0 after the edge, slice 4 written.
//  6. Sweep: write i*0x1111 to regs 0..30 back-to-back, then read each slice -> exact match.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared register-file constants and index type for the register bank,
// its scoreboard and the decoders that feed both.
package regfile_pkg;

    localparam int NREG      = 32;
    localparam int REG_AW    = 5;
    localparam int DEFAULT_N = 64;

    typedef logic [REG_AW-1:0] reg_idx_t;

    localparam reg_idx_t XZR = 5'd31;

endpackage

// File: rtl/decoder_5to32.sv
// One-hot 5-to-32 decoder with enable; all-zero output when disabled.
module decoder_5to32
    import regfile_pkg::*;
(
    input  logic             en,
    input  reg_idx_t         idx,
    output logic [NREG-1:0]  oh
);

    always_comb begin
        // NOTE: default first so every path assigns oh and no latch is inferred.
        oh = '0;
        if (en) begin
            oh[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/reg_bank_scoreboard.sv
// 32 x N architectural register bank (hardwired-zero register) with a
// single-outstanding busy scoreboard and combinational RAW hazard flags.
module reg_bank_scoreboard
    import regfile_pkg::*;
#(
    parameter int N        = DEFAULT_N,
    parameter int ZERO_REG = 31
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  reg_idx_t          wr_addr,
    input  logic [N-1:0]      wr_data,
    input  logic              issue_en,
    input  reg_idx_t          issue_rd,
    input  logic              flush,
    input  reg_idx_t          rs_a,
    input  reg_idx_t          rs_b,
    output logic [NREG*N-1:0] q_all,
    output logic [NREG-1:0]   busy,
    output logic              hazard_a,
    output logic              hazard_b,
    output logic              stall
);

    localparam reg_idx_t ZR = reg_idx_t'(ZERO_REG);

    logic            wr_ok;
    logic            set_ok;
    logic [NREG-1:0] wr_oh;
    logic [NREG-1:0] set_oh;
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_next;

    // Zero-register accesses are filtered before decode, so neither one-hot
    // vector can ever touch the zero register.
    assign wr_ok  = wr_en    && (wr_addr  != ZR);
    assign set_ok = issue_en && (issue_rd != ZR);

    decoder_5to32 u_wr_dec (
        .en  (wr_ok),
        .idx (wr_addr),
        .oh  (wr_oh)
    );

    decoder_5to32 u_set_dec (
        .en  (set_ok),
        .idx (issue_rd),
        .oh  (set_oh)
    );

    for (genvar i = 0; i < NREG; i++) begin : g_reg
        if (i == ZERO_REG) begin : g_zero
            assign q_all[i*N +: N] = '0;
        end else begin : g_flop
            logic [N-1:0] r;

            // NOTE: every data flop is reset -- reset must clear q_all, so this
            // bank cannot be mapped to a reset-less RAM.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r <= '0;
                end else if (wr_oh[i]) begin
                    r <= wr_data;
                end
            end

            assign q_all[i*N +: N] = r;
        end
    end

    // Flush wins; a same-cycle issue to the written register keeps it busy.
    assign busy_next = flush ? '0 : ((busy_q | set_oh) & ~(wr_oh & ~set_oh));

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments for all sequential state.
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_next;
        end
    end

    assign busy     = busy_q;
    assign hazard_a = busy_q[rs_a];
    assign hazard_b = busy_q[rs_b];
    assign stall    = hazard_a | hazard_b;

endmodule

// File: tb/tb_reg_bank_scoreboard.sv
// Directed, table-driven bench for reg_bank_scoreboard plus hand-written
// sequences for async reset, zero register and the write sweep.
module tb_reg_bank_scoreboard;
    import regfile_pkg::*;

    localparam int N = 64;

    logic              clk;
    logic              rst_n;
    logic              wr_en;
    reg_idx_t          wr_addr;
    logic [N-1:0]      wr_data;
    logic              issue_en;
    reg_idx_t          issue_rd;
    logic              flush;
    reg_idx_t          rs_a;
    reg_idx_t          rs_b;
    logic [NREG*N-1:0] q_all;
    logic [NREG-1:0]   busy;
    logic              hazard_a;
    logic              hazard_b;
    logic              stall;

    int n_checks = 0;
    int n_pass   = 0;

    reg_bank_scoreboard #(.N(N), .ZERO_REG(31)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .issue_en (issue_en),
        .issue_rd (issue_rd),
        .flush    (flush),
        .rs_a     (rs_a),
        .rs_b     (rs_b),
        .q_all    (q_all),
        .busy     (busy),
        .hazard_a (hazard_a),
        .hazard_b (hazard_b),
        .stall    (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic         wr_en;
        logic [4:0]   wr_addr;
        logic [63:0]  wr_data;
        logic         issue_en;
        logic [4:0]   issue_rd;
        logic         flush;
        logic [4:0]   rs_a;
        logic [4:0]   rs_b;
        logic         exp_ha;
        logic         exp_hb;
        logic [31:0]  exp_busy;
        logic [4:0]   chk_reg;
        logic [63:0]  exp_data;
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mk(logic we, logic [4:0] wa, logic [63:0] wd,
                                logic ie, logic [4:0] ird, logic fl,
                                logic [4:0] ra, logic [4:0] rb,
                                logic ha, logic hb, logic [31:0] eb,
                                logic [4:0] cr, logic [63:0] ed);
        vec_t v;
        v.wr_en = we;  v.wr_addr = wa;  v.wr_data = wd;
        v.issue_en = ie; v.issue_rd = ird; v.flush = fl;
        v.rs_a = ra;   v.rs_b = rb;
        v.exp_ha = ha; v.exp_hb = hb; v.exp_busy = eb;
        v.chk_reg = cr; v.exp_data = ed;
        return v;
    endfunction

    function automatic logic [N-1:0] slice(int idx);
        return q_all[idx*N +: N];
    endfunction

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic idle_inputs();
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        issue_en = 1'b0; issue_rd = '0; flush = 1'b0;
        rs_a = '0; rs_b = '0;
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;

        // 1: issue/write/flush table; hazards checked before the edge,
        // busy and one register slice checked just after it.
        vecs[0]  = mk(1, 5'd5,  64'hDEAD_BEEF_0000_0001, 0, 0,     0, 0,     0,     0, 0, 32'h0,  5'd5,  64'hDEAD_BEEF_0000_0001);
        vecs[1]  = mk(1, 5'd31, '1,                      1, 5'd31, 0, 5'd31, 0,     0, 0, 32'h0,  5'd31, 64'h0);
        vecs[2]  = mk(0, 0,     0,                       1, 5'd7,  0, 0,     0,     0, 0, 32'h80, 5'd7,  64'h0);
        vecs[3]  = mk(0, 0,     0,                       0, 0,     0, 0,     5'd7,  0, 1, 32'h80, 5'd7,  64'h0);
        vecs[4]  = mk(1, 5'd7,  64'h42,                  0, 0,     0, 0,     5'd7,  0, 1, 32'h0,  5'd7,  64'h42);
        vecs[5]  = mk(0, 0,     0,                       0, 0,     0, 0,     5'd7,  0, 0, 32'h0,  5'd7,  64'h42);
        vecs[6]  = mk(0, 0,     0,                       1, 5'd3,  0, 0,     0,     0, 0, 32'h08, 5'd3,  64'h0);
        vecs[7]  = mk(1, 5'd3,  64'h33,                  1, 5'd3,  0, 5'd3,  0,     1, 0, 32'h08, 5'd3,  64'h33);
        vecs[8]  = mk(0, 0,     0,                       1, 5'd4,  0, 0,     0,     0, 0, 32'h18, 5'd3,  64'h33);
        vecs[9]  = mk(1, 5'd4,  64'h44,                  1, 5'd3,  0, 5'd3,  5'd4,  1, 1, 32'h08, 5'd4,  64'h44);
        vecs[10] = mk(1, 5'd3,  64'h3333,                1, 5'd4,  0, 5'd3,  5'd4,  1, 0, 32'h10, 5'd3,  64'h3333);
        vecs[11] = mk(0, 0,     0,                       1, 5'd5,  0, 0,     0,     0, 0, 32'h30, 5'd5,  64'hDEAD_BEEF_0000_0001);
        vecs[12] = mk(0, 0,     0,                       1, 5'd6,  0, 0,     0,     0, 0, 32'h70, 5'd31, 64'h0);
        vecs[13] = mk(0, 0,     0,                       1, 5'd7,  0, 0,     0,     0, 0, 32'hF0, 5'd7,  64'h42);
        vecs[14] = mk(1, 5'd4,  64'h4444,                1, 5'd9,  1, 5'd9,  5'd4,  0, 1, 32'h0,  5'd4,  64'h4444);
        vecs[15] = mk(0, 0,     0,                       0, 0,     0, 5'd9,  5'd4,  0, 0, 32'h0,  5'd4,  64'h4444);

        #12;
        check("reset_busy",  busy, 0);
        check("reset_q_any", |q_all, 0);
        check("reset_stall", stall, 0);
        rst_n = 1'b1;

        for (int k = 0; k < 16; k++) begin
            wr_en    = vecs[k].wr_en;    wr_addr  = vecs[k].wr_addr;
            wr_data  = vecs[k].wr_data;  issue_en = vecs[k].issue_en;
            issue_rd = vecs[k].issue_rd; flush    = vecs[k].flush;
            rs_a     = vecs[k].rs_a;     rs_b     = vecs[k].rs_b;
            #1;
            check($sformatf("v%0d_hazard_a", k), hazard_a, vecs[k].exp_ha);
            check($sformatf("v%0d_hazard_b", k), hazard_b, vecs[k].exp_hb);
            check($sformatf("v%0d_stall", k), stall, vecs[k].exp_ha | vecs[k].exp_hb);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_busy", k), busy, vecs[k].exp_busy);
            check($sformatf("v%0d_slice%0d", k, vecs[k].chk_reg), slice(int'(vecs[k].chk_reg)), vecs[k].exp_data);
        end
        idle_inputs();

        // 2: back-to-back sweep writes, then every slice read back.
        for (int i = 0; i < 31; i++) begin
            wr_en = 1'b1; wr_addr = reg_idx_t'(i); wr_data = 64'(i) * 64'h1111;
            @(posedge clk);
            #1;
        end
        idle_inputs();
        for (int i = 0; i < 31; i++) begin
            check($sformatf("sweep_slice%0d", i), slice(i), 64'(i) * 64'h1111);
        end
        check("sweep_slice31", slice(31), 0);

        // 3: async reset mid-cycle with nonzero registers and a busy bit.
        issue_en = 1'b1; issue_rd = 5'd10; rs_a = 5'd10;
        @(posedge clk);
        #1;
        issue_en = 1'b0;
        check("pre_rst_busy",  busy, 32'h400);
        check("pre_rst_stall", stall, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_busy",  busy, 0);
        check("async_rst_q_any", |q_all, 0);
        check("async_rst_stall", stall, 0);
        wr_en = 1'b1; wr_addr = 5'd6; wr_data = 64'h1234;
        @(posedge clk);
        #1;
        check("rst_held_slice6", slice(6), 0);
        rst_n = 1'b1;
        wr_addr = 5'd5; wr_data = 64'hDEAD_BEEF_0000_0001;
        @(posedge clk);
        #1;
        idle_inputs();
        check("post_rst_slice5", slice(5), 64'hDEAD_BEEF_0000_0001);
        check("post_rst_slice6", slice(6), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
